// File: rtl/ssp_tx_fifo_pclk.sv
// SSP transmit FIFO, PCLK side: APB pushes in, synchronised SSPCLK pop requests drain it.
// Define SSP_TX_OVERFLOW_FLAG_EN to add the sticky TxFOvrFlag output for dropped pushes.
module ssp_tx_fifo_pclk #(
   parameter int DW = 16,
   parameter int AW = 3
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   input  logic          TxFWr,
   input  logic [DW-1:0] TxFWrData,
   input  logic          TxFClr,
   input  logic          TxFRdPtrIncSync,
   input  logic          TxRxBSYSync,
   output logic [DW-1:0] TxFData,
   output logic          TxFEmpty,
   output logic          TxFNotFull,
   output logic          TxFHalfEmpty,
`ifdef SSP_TX_OVERFLOW_FLAG_EN
   output logic          SSPBSY,
   output logic          TxFOvrFlag
`else
   output logic          SSPBSY
`endif
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] HALF  = DEPTH >> 1;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          inc_prev;

   logic pop_req;
   logic is_full;
   logic is_empty;
   logic push_ok;
   logic pop_ok;

   // A held pop level counts once; only the rising edge pops.
   assign pop_req  = TxFRdPtrIncSync & ~inc_prev;
   assign is_full  = (count == DEPTH);
   assign is_empty = (count == '0);
   assign push_ok  = TxFWr & ~is_full;
   assign pop_ok   = pop_req & ~is_empty;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         inc_prev <= 1'b0;
      end else begin
         inc_prev <= TxFRdPtrIncSync;
         if (TxFClr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

   // Storage is deliberately unreset; the pointers alone define validity.
   always_ff @(posedge PCLK) begin
      if (push_ok && !TxFClr && PRESETn)
         mem[wr_ptr] <= TxFWrData;
   end

`ifdef SSP_TX_OVERFLOW_FLAG_EN
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)
         TxFOvrFlag <= 1'b0;
      else if (TxFClr)
         TxFOvrFlag <= 1'b0;
      else if (TxFWr && is_full)
         TxFOvrFlag <= 1'b1;
   end
`endif

   assign TxFData      = mem[rd_ptr];
   assign TxFEmpty     = is_empty;
   assign TxFNotFull   = ~is_full;
   assign TxFHalfEmpty = (count <= HALF);
   assign SSPBSY       = TxRxBSYSync | ~is_empty;

endmodule

// File: doc/ssp_tx_fifo_pclk.md
SSP_TX_FIFO_PCLK -- requirements
Module: ssp_tx_fifo_pclk

Interface
REQ-001 SHALL provide parameter DW, default 16, FIFO entry data width in bits.
REQ-002 SHALL provide parameter AW, default 3, pointer width, giving a FIFO depth of 2^AW (8) entries.
REQ-003 SHALL provide port PCLK  input  1  APB bus clock, the only clock.
REQ-004 SHALL provide port PRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port TxFWr  input  1  push strobe, one cycle per APB write to the data register.
REQ-006 SHALL provide port TxFWrData  input  DW  push data.
REQ-007 SHALL provide port TxFClr  input  1  synchronous flush request.
REQ-008 SHALL provide port TxFRdPtrIncSync  input  1  pop request level, already double-synchronised from the SSPCLK domain.
REQ-009 SHALL provide port TxRxBSYSync  input  1  serial engine busy, already synchronised.
REQ-010 SHALL provide port TxFData  output  DW  entry at the read pointer, sampled by the SSPCLK domain.
REQ-011 SHALL provide port TxFEmpty  output  1  FIFO empty (TFE).
REQ-012 SHALL provide port TxFNotFull  output  1  FIFO not full (TNF).
REQ-013 SHALL provide port TxFHalfEmpty  output  1  occupancy <= depth/2, which is the raw TX interrupt.
REQ-014 SHALL provide port SSPBSY  output  1  busy status.
REQ-015 SHALL provide port TxFOvrFlag  output  1  sticky overflow flag; present only when the macro in REQ-033 is defined.

Function
REQ-016 SHALL store entries in a 2^AW x DW register array, with AW-bit write and read pointers that wrap modulo 2^AW and an (AW+1)-bit occupancy count of 0..2^AW.
REQ-017 SHALL generate a pop event on the rising edge of TxFRdPtrIncSync, detected with a one-register delay (pop = TxFRdPtrIncSync & ~prev).
REQ-018 SHALL treat one sustained high level on TxFRdPtrIncSync as exactly one pop, and SHALL ignore its falling edge.
REQ-019 SHALL accept a push when TxFWr=1 and count < 2^AW: write mem[wrptr], increment wrptr, increment count.
REQ-020 SHALL drop a push when count = 2^AW, with no change to memory, pointers or count.
REQ-021 SHALL accept a pop when count > 0: increment rdptr, decrement count; SHALL ignore a pop when count = 0.
REQ-022 SHALL evaluate full and empty on the pre-edge count when a push and a pop occur in the same cycle:
- Full: pop accepted, push dropped, count becomes 2^AW-1.
- Empty: push accepted, pop ignored, count becomes 1.
- Otherwise: both accepted, count unchanged.
REQ-023 SHALL give TxFClr priority over push and pop, setting wrptr, rdptr and count to 0 on the next edge; the edge-detect register SHALL still update during TxFClr.
REQ-024 SHALL drive TxFData combinationally as mem[rdptr], so it changes only after an accepted pop or push-into-empty, and is stable for at least the synchroniser round-trip.
REQ-025 SHALL decode the flags from the registered count:
- TxFEmpty = (count = 0).
- TxFNotFull = (count < 2^AW).
- TxFHalfEmpty = (count <= 2^(AW-1)).
REQ-026 SHALL make every flag reflect an event on the first PCLK edge after that event, giving one cycle of latency.
REQ-027 SHALL drive SSPBSY = TxRxBSYSync | ~TxFEmpty.
REQ-028 SHALL show the effect of a pop on the flags no earlier than 1 cycle after TxFRdPtrIncSync rises.

Reset
REQ-029 SHALL asynchronously clear, on PRESETn=0: wrptr, rdptr, count, the edge-detect register and TxFOvrFlag.
REQ-030 SHALL drive the following outputs during and after reset until the first event: TxFEmpty=1, TxFNotFull=1, TxFHalfEmpty=1, SSPBSY=TxRxBSYSync, TxFOvrFlag=0.
REQ-031 SHALL leave the memory array unreset, so TxFData is undefined until the first push.
REQ-032 SHALL abandon any in-progress push or pop when reset is asserted mid-operation, leaving no partial update.

Configuration
REQ-033 SHALL, when macro SSP_TX_OVERFLOW_FLAG_EN is defined:
- set TxFOvrFlag on the edge after a dropped push (REQ-020);
- hold it until TxFClr or reset.
REQ-034 SHALL, when SSP_TX_OVERFLOW_FLAG_EN is undefined:
- omit the TxFOvrFlag port and its register;
- discard dropped pushes silently.

Verification
REQ-035 SHALL cover reset then push 0x1234 -> next cycle TxFEmpty=0, TxFData=0x1234, SSPBSY=1, TxFHalfEmpty=1.
REQ-036 SHALL cover push 8 words 0x0001..0x0008 then push 0x00FF -> TxFNotFull=0, count=8, 0x00FF discarded, TxFOvrFlag=1 (macro on).
REQ-037 SHALL cover a full FIFO with TxFRdPtrIncSync held high 5 cycles -> exactly one pop, count=7, TxFData=0x0002.
REQ-038 SHALL cover an empty FIFO with push 0xABCD and pop in the same cycle -> count=1, TxFData=0xABCD.
REQ-039 SHALL cover 4 entries with TxFClr plus a simultaneous push -> count=0, TxFEmpty=1, TxFOvrFlag=0, SSPBSY=TxRxBSYSync.
REQ-040 SHALL cover 12 push/pop pairs (pointer wrap) -> data returned in order with no loss; TxFHalfEmpty toggles exactly at count 5->4.
